as_gpio_arb: RTL and testbench

AS_GPIO_ARB -- requirements
Module: as_gpio_arb

---
 rtl/as_gpio_arb.sv | 108 ++++++++++
 tb/tb_as_gpio_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/as_gpio_arb.sv
`default_nettype none
// as_gpio_arb: two-requester round-robin arbiter driving a strobed, registered GPIO write port.
// Rev 1.0 - initial release
module as_gpio_arb #(
  parameter int GPIO_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [GPIO_W-1:0] data0_i,
  output logic              ack0_o,
  input  logic              req1_i,
  input  logic [GPIO_W-1:0] data1_i,
  output logic              ack1_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              gpio_oe_o,
  output logic              cs_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] C_HOLD_LOAD = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_last;
  logic [GPIO_W-1:0] r_gpio;
  logic              r_oe;
  logic              r_cs;
  logic              r_busy;
  logic              r_ack0;
  logic              r_ack1;
  logic              w_grant;
  logic              w_gnt1;

  // On a tie, the requester not named by the last-grant pointer wins.
  assign w_gnt1 = req1_i & (~req0_i | ~r_last);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          w_next  = S_SETUP;
          w_grant = 1'b1;
        end
      end
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: w_next = (HOLD_CYC > 0) ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (r_cnt == 4'd0) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gpio <= '0;
      r_oe   <= 1'b0;
      r_cs   <= 1'b0;
      r_busy <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_cnt  <= 4'd0;
      r_last <= 1'b1;
    end else begin
      r_ack0 <= w_grant & ~w_gnt1;
      r_ack1 <= w_grant & w_gnt1;
      r_cs   <= (w_next == S_STROBE);
      r_busy <= (w_next != S_IDLE);
      if (w_grant) begin
        r_gpio <= w_gnt1 ? data1_i : data0_i;
        r_oe   <= 1'b1;
        r_last <= w_gnt1;
      end
      if (r_state == S_STROBE) begin
        r_cnt <= C_HOLD_LOAD;
      end else if ((r_state == S_HOLD) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign ack0_o    = r_ack0;
  assign ack1_o    = r_ack1;
  assign gpio_o    = r_gpio;
  assign gpio_oe_o = r_oe;
  assign cs_o      = r_cs;
  assign busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_as_gpio_arb.sv
`default_nettype none
// tb_as_gpio_arb: scoreboard-based self-checking bench for as_gpio_arb (HOLD_CYC=2 and HOLD_CYC=0 instances).
module tb_as_gpio_arb;
  localparam int W = 8;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         ack0, ack1, cs, oe, busy;
  logic [W-1:0] gpio;

  logic         zreq = 1'b0;
  logic [W-1:0] zdat = '0;
  logic         req1_b = 1'b0;
  logic [W-1:0] d1_b = '0;
  logic         ack0_b, ack1_b, cs_b, oe_b, busy_b;
  logic [W-1:0] gpio_b;

  as_gpio_arb #(.GPIO_W(W), .HOLD_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .data0_i(d0), .ack0_o(ack0),
    .req1_i(req1), .data1_i(d1), .ack1_o(ack1),
    .gpio_o(gpio), .gpio_oe_o(oe), .cs_o(cs), .busy_o(busy)
  );

  as_gpio_arb #(.GPIO_W(W), .HOLD_CYC(0)) dut_h0 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(zreq), .data0_i(zdat), .ack0_o(ack0_b),
    .req1_i(req1_b), .data1_i(d1_b), .ack1_o(ack1_b),
    .gpio_o(gpio_b), .gpio_oe_o(oe_b), .cs_o(cs_b), .busy_o(busy_b)
  );

  always #5 clk = ~clk;

  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] sb[$];
  int           cs_times[$];
  logic [W-1:0] mon_exp;
  logic         prev_cs = 1'b0, prev_cs_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol invariants plus the scoreboard check of every strobe on the HOLD_CYC=2 instance.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (ack0 && ack1) begin bad++; $display("FAIL ack_exclusive ack0=%b ack1=%b expected not both high", ack0, ack1); end
      total++;
      if (cs && prev_cs) begin bad++; $display("FAIL cs_single cs high two cycles in a row at cyc=%0d", cyc); end
      total++;
      if (ack0_b && ack1_b) begin bad++; $display("FAIL ack_exclusive_h0 ack0=%b ack1=%b expected not both high", ack0_b, ack1_b); end
      total++;
      if (cs_b && prev_cs_b) begin bad++; $display("FAIL cs_single_h0 cs high two cycles in a row at cyc=%0d", cyc); end
      if (cs) begin
        cs_times.push_back(cyc);
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL cs_unexpected gpio=0x%02h with no pending write", gpio);
        end else begin
          mon_exp = sb.pop_front();
          if (gpio !== mon_exp) begin bad++; $display("FAIL cs_data gpio=0x%02h expected 0x%02h", gpio, mon_exp); end
        end
      end
    end
    prev_cs   = cs;
    prev_cs_b = cs_b;
  end

  task automatic wait_ack(input int idx, input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (idx == 0 ? ack0 : ack1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s ack%0d not seen within 30 cycles, expected an ack", name, idx); end
  endtask

  task automatic wait_any(output int who);
    who = -1;
    for (int i = 0; i < 30 && who < 0; i++) begin
      @(negedge clk);
      if (ack0)      who = 0;
      else if (ack1) who = 1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL %s pending writes=%0d expected 0", name, sb.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gpio, oe, cs, ack0, ack1, busy} !== {(W+5){1'b0}})
      begin bad++; $display("FAIL reset_outputs gpio=%h oe=%b cs=%b ack0=%b ack1=%b busy=%b expected all 0", gpio, oe, cs, ack0, ack1, busy); end
    total++;
    if ({gpio_b, oe_b, cs_b, ack0_b, ack1_b, busy_b} !== {(W+5){1'b0}})
      begin bad++; $display("FAIL reset_outputs_h0 gpio=%h oe=%b cs=%b busy=%b expected all 0", gpio_b, oe_b, cs_b, busy_b); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0 = 1'b1; d0 = 8'd137; sb.push_back(8'd137);
    @(negedge clk);
    total++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_pre ack0=%b busy=%b expected 0 0", ack0, busy); end
    @(negedge clk);
    total++;
    if (ack0 !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_ack ack0=%b busy=%b expected 1 1", ack0, busy); end
    total++;
    if (gpio !== 8'd137 || oe !== 1'b1) begin bad++; $display("FAIL single_setup gpio=%0d oe=%b expected 137 1", gpio, oe); end
    req0 = 1'b0;
    @(negedge clk);
    total++;
    if (cs !== 1'b1 || ack0 !== 1'b0) begin bad++; $display("FAIL single_cs cs=%b ack0=%b expected 1 0", cs, ack0); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || cs !== 1'b0) begin bad++; $display("FAIL single_hold%0d busy=%b cs=%b expected 1 0", i, busy, cs); end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b expected 0", busy); end
    drain("single");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals[4];
    int  base;
    bit  seen;
    vals = '{8'd137, 8'd119, 8'd1, 8'd254};
    base = cs_times.size();
    @(posedge clk); #1;
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = vals[i];
      sb.push_back(vals[i]);
      wait_ack(0, "b2b", seen);
    end
    req0 = 1'b0;
    drain("b2b");
    repeat (8) @(negedge clk);
    total++;
    if (cs_times.size() - base != 4) begin bad++; $display("FAIL b2b_count cs pulses=%0d expected 4", cs_times.size() - base); end
    if (cs_times.size() >= base + 4) begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (cs_times[base+i] - cs_times[base+i-1] != 5)
          begin bad++; $display("FAIL b2b_gap%0d gap=%0d expected 5", i, cs_times[base+i] - cs_times[base+i-1]); end
      end
    end
  endtask

  task automatic tie_pair(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int who;
    req0 = 1'b1; req1 = 1'b1; d0 = a; d1 = b;
    sb.push_back(a); sb.push_back(b);
    wait_any(who);
    total++;
    if (who !== 0) begin bad++; $display("FAIL %s_first granted=%0d expected 0", name, who); end
    if (who == 0) req0 = 1'b0;
    else if (who == 1) req1 = 1'b0;
    wait_any(who);
    total++;
    if (who !== 1) begin bad++; $display("FAIL %s_second granted=%0d expected 1", name, who); end
    req0 = 1'b0; req1 = 1'b0;
    drain(name);
  endtask

  task automatic test_tie();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tie_pair(8'h11, 8'h22, "tie1");
    repeat (6) @(negedge clk);
    tie_pair(8'h33, 8'h44, "tie2");
    repeat (8) @(negedge clk);
    total++;
    if (gpio !== 8'h44 || oe !== 1'b1) begin bad++; $display("FAIL tie_hold gpio=0x%02h oe=%b expected 0x44 1", gpio, oe); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req0 = 1'b1; d0 = 8'hFE; sb.push_back(8'hFE);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ack0 !== 1'b1) begin bad++; $display("FAIL rstmid_setup ack0=%b expected 1", ack0); end
    rst = 1'b1;
    #1;
    total++;
    if ({gpio, oe, cs, ack0, ack1, busy} !== {(W+5){1'b0}})
      begin bad++; $display("FAIL rstmid_async gpio=%h oe=%b cs=%b ack0=%b busy=%b expected all 0", gpio, oe, cs, ack0, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cs !== 1'b0) begin bad++; $display("FAIL rstmid_nocs%0d cs=%b expected 0", i, cs); end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ack0 !== 1'b1) begin bad++; $display("FAIL rstmid_regrant ack0=%b expected 1", ack0); end
    req0 = 1'b0;
    drain("rstmid");
  endtask

  task automatic test_hold0();
    int ack_t[$];
    int cs_t[$];
    @(posedge clk); #1;
    req1_b = 1'b1; d1_b = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ack1_b) ack_t.push_back(i);
      if (cs_b) begin
        cs_t.push_back(i);
        total++;
        if (gpio_b !== 8'hA5) begin bad++; $display("FAIL h0_data gpio=0x%02h expected 0xa5", gpio_b); end
      end
    end
    req1_b = 1'b0;
    total++;
    if (ack_t.size() < 4 || cs_t.size() < 4) begin bad++; $display("FAIL h0_count acks=%0d cs=%0d expected at least 4 each", ack_t.size(), cs_t.size()); end
    if (ack_t.size() >= 1 && cs_t.size() >= 1) begin
      total++;
      if (ack_t[0] != 1 || cs_t[0] != 2) begin bad++; $display("FAIL h0_latency ack@%0d cs@%0d expected 1 2", ack_t[0], cs_t[0]); end
    end
    for (int i = 1; i < ack_t.size(); i++) begin
      total++;
      if (ack_t[i] - ack_t[i-1] != 3) begin bad++; $display("FAIL h0_ack_gap%0d gap=%0d expected 3", i, ack_t[i] - ack_t[i-1]); end
    end
    for (int i = 1; i < cs_t.size(); i++) begin
      total++;
      if (cs_t[i] - cs_t[i-1] != 3) begin bad++; $display("FAIL h0_cs_gap%0d gap=%0d expected 3", i, cs_t[i] - cs_t[i-1]); end
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tie();
    test_reset_mid();
    test_hold0();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
